// File: rtl/hit_scorer_pkg.sv
// Shared types and constants for the hit scorer.
// Holds state encoding, level select codes and default thresholds.
package hit_scorer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam logic [1:0] SEL_L1 = 2'b00;
    localparam logic [1:0] SEL_L2 = 2'b01;
    localparam logic [1:0] SEL_L3 = 2'b11;

    localparam int unsigned DEF_L2_THRESH  = 20;
    localparam int unsigned DEF_L3_THRESH  = 50;
    localparam int unsigned DEF_LIVES_INIT = 3;
    localparam int unsigned DEF_SCORE_MAX  = 999;

    // Level is a pure function of score, so it is monotonic within a game.
    function automatic logic [1:0] level_sel(
        input logic [9:0] s,
        input logic [9:0] t2,
        input logic [9:0] t3
    );
        if (s >= t3)      return SEL_L3;
        else if (s >= t2) return SEL_L2;
        else              return SEL_L1;
    endfunction

endpackage

// File: rtl/hit_scorer_lane_judge.sv
// Target register, press latch and per-window hit/miss decision.
// Exposes the decision combinationally for the counters and as registered pulses.
module lane_judge
    import hit_scorer_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       active,
    input  logic       tick,
    input  logic [3:0] zone,
    input  logic [3:0] press,
    output logic       hit_evt,
    output logic       miss_evt,
    output logic       hit,
    output logic       miss
);

    logic [3:0] target;
    logic [3:0] latch;
    logic       armed;
    logic [3:0] window;
    logic       judge;
    logic       match;
    logic       quiet;

    always_comb begin
        window   = latch | press;
        judge    = active && tick && armed;
        match    = (target != 4'd0) && (window == target);
        quiet    = (target == 4'd0) && (window == 4'd0);
        hit_evt  = judge && match;
        miss_evt = judge && !match && !quiet;
    end

    // armed stays low until the first tick of a game has captured a target.
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            target <= 4'd0;
            latch  <= 4'd0;
            armed  <= 1'b0;
            hit    <= 1'b0;
            miss   <= 1'b0;
        end else begin
            hit  <= hit_evt;
            miss <= miss_evt;
            if (active) begin
                if (tick) begin
                    target <= zone;
                    latch  <= 4'd0;
                    armed  <= 1'b1;
                end else begin
                    latch <= latch | press;
                end
            end
        end
    end

endmodule

// File: rtl/hit_scorer.sv
// Rhythm-game scorer: game FSM, score/lives counters and level select.
// Lane judgement lives in lane_judge.
module hit_scorer
    import hit_scorer_pkg::*;
#(
    parameter int unsigned L2_THRESH  = DEF_L2_THRESH,
    parameter int unsigned L3_THRESH  = DEF_L3_THRESH,
    parameter int unsigned LIVES_INIT = DEF_LIVES_INIT,
    parameter int unsigned SCORE_MAX  = DEF_SCORE_MAX
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        tick,
    input  logic [15:0] pattern,
    input  logic [3:0]  press,
    output logic [1:0]  select,
    output logic [9:0]  score,
    output logic [1:0]  lives,
    output logic        hit,
    output logic        miss,
    output logic        playing,
    output logic        game_over
);

    localparam logic [9:0] T2    = 10'(L2_THRESH);
    localparam logic [9:0] T3    = 10'(L3_THRESH);
    localparam logic [9:0] SMAX  = 10'(SCORE_MAX);
    localparam logic [1:0] LINIT = 2'(LIVES_INIT);

    state_t state;
    state_t state_nx;
    logic   active;
    logic   hit_evt;
    logic   miss_evt;
    logic   unused_bits;

    assign unused_bits = ^pattern[15:4];

    // start overrides any coincident tick.
    assign active = (state == S_PLAY) && !start;

    lane_judge u_judge (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (start),
        .active   (active),
        .tick     (tick),
        .zone     (pattern[3:0]),
        .press    (press),
        .hit_evt  (hit_evt),
        .miss_evt (miss_evt),
        .hit      (hit),
        .miss     (miss)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_OVER: if (start) state_nx = S_PLAY;
            S_PLAY: begin
                if (start)
                    state_nx = S_PLAY;
                else if (miss_evt && lives <= 2'd1)
                    state_nx = S_OVER;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        playing   = (state == S_PLAY);
        game_over = (state == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (!resetn || start) begin
            score <= 10'd0;
            lives <= LINIT;
        end else if (state == S_PLAY) begin
            if (hit_evt && score < SMAX)
                score <= score + 10'd1;
            if (miss_evt && lives != 2'd0)
                lives <= lives - 2'd1;
        end
    end

    always_comb select = level_sel(score, T2, T3);

endmodule

// File: doc/hit_scorer.md
HIT_SCORER -- requirements
Module: hit_scorer

Interface
REQ-001 The parameter list SHALL be: L2_THRESH, 20, score at which level 2 is entered.
REQ-002 The parameter list SHALL continue: L3_THRESH, 50, score at which level 3 is entered.
REQ-003 The parameter list SHALL continue: LIVES_INIT, 3, lives at game start; SCORE_MAX, 999, score saturation value.
REQ-004 Ports SHALL be as follows; the block has one clock, and reset is synchronous and active-low.
REQ-005 Port: clk, input, 1, system clock; all state changes on its rising edge.
REQ-006 Port: resetn, input, 1, synchronous active-low reset.
REQ-007 Port: start, input, 1, one-cycle pulse that begins a new game.
REQ-008 Port: tick, input, 1, one-cycle pulse marking each advance of the combined light pattern.
REQ-009 Port: pattern, input, 16, combined light pattern; bits [3:0] form the judge zone, one bit per lane.
REQ-010 Port: press, input, 4, player lane buttons, active-high, already synchronised.
REQ-011 Port: select, output, 2, level code for the pattern combiner: 00 = level 1, 01 = level 2, 11 = level 3.
REQ-012 Port: score, output, 10, binary hit count.
REQ-013 Port: lives, output, 2, remaining lives.
REQ-014 Port: hit, output, 1, one-cycle pulse on a correct judgement.
REQ-015 Port: miss, output, 1, one-cycle pulse on a wrong judgement.
REQ-016 Port: playing, output, 1, high in the PLAY state.
REQ-017 Port: game_over, output, 1, high in the OVER state.

Function
REQ-018 The FSM SHALL have three states: IDLE, PLAY and OVER.
REQ-019 IDLE and OVER SHALL move to PLAY on start; PLAY SHALL move to OVER when lives reach 0.
REQ-020 Entering PLAY SHALL clear score, streak, the target register and the press latch, set lives to LIVES_INIT and set select to 00.
REQ-021 In PLAY, on each tick the block SHALL capture pattern[3:0] into the target register; the target is judged at the following tick.
REQ-022 In PLAY, the press latch SHALL OR in press every cycle; it is judged and cleared on each tick.
REQ-023 A press in the same cycle as a tick SHALL be included in the window being closed.
REQ-024 Judgement SHALL be as follows: target == 0 and latch == 0 gives no event.
REQ-025 Judgement: latch == target with target != 0 SHALL give a hit.
REQ-026 Judgement: every other combination SHALL give a miss, including a press when target == 0.
REQ-027 The first tick after entering PLAY SHALL only capture the target and SHALL NOT judge.
REQ-028 On a hit, score SHALL increment by 1, saturating at SCORE_MAX.
REQ-029 On a miss, lives SHALL decrement by 1 and SHALL NOT wrap below 0.
REQ-030 The hit and miss outputs SHALL be registered: high for exactly one cycle, starting the cycle after the tick edge.
REQ-031 Level: select SHALL become 01 when score >= L2_THRESH, and 11 when score >= L3_THRESH.
REQ-032 Level changes SHALL take effect the same cycle the updated score is visible.
REQ-033 Select SHALL never decrease during a game and SHALL never take the value 10.
REQ-034 A miss that brings lives to 0 SHALL enter OVER on the same edge the miss pulse is raised.
REQ-035 In OVER, score, select and lives SHALL hold, and tick and press SHALL be ignored.
REQ-036 If start and tick coincide, start SHALL win and that tick SHALL be ignored.
REQ-037 In IDLE, tick and press SHALL be ignored.

Reset
REQ-038 When resetn is 0 at a clock edge, the block SHALL enter IDLE with score = 0, lives = LIVES_INIT, select = 00, and hit, miss, playing and game_over = 0.
REQ-039 Reset SHALL clear the target register and press latch, override all other inputs, and apply mid-game with no residual pulse.

Structure
REQ-040 A shared package SHALL hold the state encoding, the select codes (SEL_L1 = 00, SEL_L2 = 01, SEL_L3 = 11) and the default thresholds.
REQ-041 One sub-module, lane_judge, SHALL hold the target register, press latch and hit/miss decision; the top level holds the FSM, counters and level logic.

Verification
REQ-042 Scenario: reset, start, tick with pattern[3:0] = 0101, then press = 0101 for 1 cycle, then tick -> hit pulse 1 cycle, score = 1, lives = 3.
REQ-043 Scenario: target 0011, press 0001 only, then tick -> miss pulse, lives = 2, score unchanged; next target 0000 with press 0010, then tick -> miss, lives = 1.
REQ-044 Scenario: 20 consecutive hits -> select = 01 when score = 20; continue to 50 hits -> select = 11; 10 is never seen.
REQ-045 Scenario: three misses -> lives = 0, game_over = 1 at the third miss pulse; further ticks leave score frozen; start -> PLAY, score = 0, lives = 3, select = 00.
REQ-046 Scenario: start and tick in the same cycle -> no capture; press asserted on a tick cycle is counted in that window; resetn low mid-game -> IDLE, all outputs at reset values next cycle.
REQ-047 Scenario: force score to 999 via hits (SCORE_MAX = 999) -> further hits pulse hit but score stays 999.
